// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback queue.
// The XZR register number and the default-width queue entry.
package wb_pkg;

    localparam logic [4:0] XZR   = 5'd31;
    localparam int         WB_AW = 5;
    localparam int         WB_DW = 64;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied queue slots, oldest (head) to youngest.
// Purely combinational; the last matching slot in age order wins.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]              rdArr   [DEPTH],
    input  logic [DW-1:0]              dataArr [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              look,
    output logic                       hit,
    output logic [DW-1:0]              data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    slotIdx [DEPTH];
    logic [DEPTH-1:0] match;
    logic             lookIsXzr;

    assign lookIsXzr = (look == AW'(XZR));

    // Slot gi holds the entry that is gi places younger than the head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slotIdx[gi] = head + PW'(gi);
            assign match[gi]   = (CW'(gi) < count) && (rdArr[slotIdx[gi]] == look) && !lookIsXzr;
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                hit  = 1'b1;
                data = dataArr[slotIdx[i]];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue between the ALU/memory stages and the register file.
// One accept (memory first) and one retire per cycle, with operand forwarding.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic                     Clk,
    input  logic                     ResetL,
    input  logic                     AluValid,
    output logic                     AluReady,
    input  logic [AW-1:0]            AluRd,
    input  logic [DW-1:0]            AluData,
    input  logic                     MemValid,
    output logic                     MemReady,
    input  logic [AW-1:0]            MemRd,
    input  logic [DW-1:0]            MemData,
    input  logic                     WrStall,
    output logic                     RegWr,
    output logic [AW-1:0]            RW,
    output logic [DW-1:0]            BusW,
    input  logic [AW-1:0]            LookA,
    input  logic [AW-1:0]            LookB,
    output logic                     FwdHitA,
    output logic                     FwdHitB,
    output logic [DW-1:0]            FwdDataA,
    output logic [DW-1:0]            FwdDataB,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] entryRd   [DEPTH];
    logic [DW-1:0] entryData [DEPTH];
    logic [PW-1:0] headReg;
    logic [PW-1:0] tailReg;
    logic [CW-1:0] countReg;

    logic          notFull;
    logic          notEmpty;
    logic          memFire;
    logic          aluFire;
    logic          push;
    logic          pop;
    logic [AW-1:0] pushRd;
    logic [DW-1:0] pushData;

    assign notFull  = (countReg < CW'(DEPTH));
    assign notEmpty = (countReg != '0);

    // Ready depends only on the pre-edge count, so a full queue never passes through.
    assign MemReady = notFull;
    assign AluReady = notFull & ~MemValid;
    assign memFire  = MemValid & MemReady;
    assign aluFire  = AluValid & AluReady;

    assign pushRd   = memFire ? MemRd   : AluRd;
    assign pushData = memFire ? MemData : AluData;
    // Writes to XZR complete the handshake but never occupy a slot.
    assign push     = (memFire | aluFire) && (pushRd != AW'(XZR));

    assign RegWr = notEmpty & ~WrStall;
    assign pop   = RegWr;
    assign RW    = notEmpty ? entryRd[headReg]   : '0;
    assign BusW  = notEmpty ? entryData[headReg] : '0;
    assign Count = countReg;

    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            if (push) begin
                tailReg <= tailReg + PW'(1);
            end
            if (pop) begin
                headReg <= headReg + PW'(1);
            end
            countReg <= countReg + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge Clk) begin
        if (push) begin
            entryRd[tailReg]   <= pushRd;
            entryData[tailReg] <= pushData;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwdA (
        .rdArr   (entryRd),
        .dataArr (entryData),
        .head    (headReg),
        .count   (countReg),
        .look    (LookA),
        .hit     (FwdHitA),
        .data    (FwdDataA)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwdB (
        .rdArr   (entryRd),
        .dataArr (entryData),
        .head    (headReg),
        .count   (countReg),
        .look    (LookB),
        .hit     (FwdHitB),
        .data    (FwdDataB)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scenario bench for writeback_queue: expected writes are queued as stimulus is
// driven and retired against RegWr/RW/BusW at every falling edge.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int AW    = 5;

    logic          Clk;
    logic          ResetL;
    logic          AluValid;
    logic          AluReady;
    logic [AW-1:0] AluRd;
    logic [DW-1:0] AluData;
    logic          MemValid;
    logic          MemReady;
    logic [AW-1:0] MemRd;
    logic [DW-1:0] MemData;
    logic          WrStall;
    logic          RegWr;
    logic [AW-1:0] RW;
    logic [DW-1:0] BusW;
    logic [AW-1:0] LookA;
    logic [AW-1:0] LookB;
    logic          FwdHitA;
    logic          FwdHitB;
    logic [DW-1:0] FwdDataA;
    logic [DW-1:0] FwdDataB;
    logic [2:0]    Count;

    int            assertCount = 0;
    int            errCount    = 0;
    wb_entry_t     expQ[$];
    wb_entry_t     monEntry;

    writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .Clk      (Clk),
        .ResetL   (ResetL),
        .AluValid (AluValid),
        .AluReady (AluReady),
        .AluRd    (AluRd),
        .AluData  (AluData),
        .MemValid (MemValid),
        .MemReady (MemReady),
        .MemRd    (MemRd),
        .MemData  (MemData),
        .WrStall  (WrStall),
        .RegWr    (RegWr),
        .RW       (RW),
        .BusW     (BusW),
        .LookA    (LookA),
        .LookB    (LookB),
        .FwdHitA  (FwdHitA),
        .FwdHitB  (FwdHitB),
        .FwdDataA (FwdDataA),
        .FwdDataB (FwdDataB),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Every register-file write must match the oldest outstanding expected write.
    always @(negedge Clk) begin
        if (ResetL === 1'b1 && RegWr !== 1'b0) begin
            assertCount++;
            if (expQ.size() == 0) begin
                errCount++;
                $display("FAIL unexpected_write: got RegWr=%b RW=%0d BusW=%0h, required no write", RegWr, RW, BusW);
            end else begin
                monEntry = expQ.pop_front();
                if (RegWr !== 1'b1 || RW !== monEntry.rd || BusW !== monEntry.data) begin
                    errCount++;
                    $display("FAIL write_order: got RW=%0d BusW=%0h, required RW=%0d BusW=%0h",
                             RW, BusW, monEntry.rd, monEntry.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic toNeg();
        @(negedge Clk);
    endtask

    task automatic expectWrite(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        ResetL = 1'b0; AluValid = 1'b0; MemValid = 1'b0; WrStall = 1'b0;
        AluRd = '0; AluData = '0; MemRd = '0; MemData = '0; LookA = 5'd0; LookB = 5'd1;
        step();
        step();
        ResetL = 1'b1;
        toNeg();
        assertCount++;
        if (Count !== 3'd0 || RegWr !== 1'b0 || RW !== 5'd0 || BusW !== 64'd0) begin
            errCount++;
            $display("FAIL reset_port: got Count=%0d RegWr=%b RW=%0d BusW=%0h, required 0 0 0 0", Count, RegWr, RW, BusW);
        end
        assertCount++;
        if (FwdHitA !== 1'b0 || FwdHitB !== 1'b0 || FwdDataA !== 64'd0 || FwdDataB !== 64'd0) begin
            errCount++;
            $display("FAIL reset_fwd: got hits=%b%b data=%0h/%0h, required all 0", FwdHitA, FwdHitB, FwdDataA, FwdDataB);
        end
        assertCount++;
        if (AluReady !== 1'b1 || MemReady !== 1'b1) begin
            errCount++;
            $display("FAIL reset_ready: got Alu=%b Mem=%b, required 1 1", AluReady, MemReady);
        end
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        AluValid = 1'b1; AluRd = 5'd3; AluData = 64'hA5;
        expectWrite(5'd3, 64'hA5);
        toNeg();
        assertCount++;
        if (AluReady !== 1'b1) begin
            errCount++;
            $display("FAIL single_ready: got %b, required 1", AluReady);
        end
        step();
        AluValid = 1'b0;
        toNeg();
        assertCount++;
        if (RegWr !== 1'b1 || RW !== 5'd3 || BusW !== 64'hA5 || Count !== 3'd1) begin
            errCount++;
            $display("FAIL single_latency: got RegWr=%b RW=%0d BusW=%0h Count=%0d, required 1 3 a5 1", RegWr, RW, BusW, Count);
        end
        step();
        toNeg();
        assertCount++;
        if (Count !== 3'd0 || RegWr !== 1'b0) begin
            errCount++;
            $display("FAIL single_drained: got Count=%0d RegWr=%b, required 0 0", Count, RegWr);
        end
        step();
        $display("test_single_alu done");
    endtask

    task automatic test_arbitration();
        MemValid = 1'b1; MemRd = 5'd4; MemData = 64'h44;
        AluValid = 1'b1; AluRd = 5'd5; AluData = 64'h55;
        expectWrite(5'd4, 64'h44);
        expectWrite(5'd5, 64'h55);
        toNeg();
        assertCount++;
        if (MemReady !== 1'b1 || AluReady !== 1'b0) begin
            errCount++;
            $display("FAIL arb_priority: got Mem=%b Alu=%b, required 1 0", MemReady, AluReady);
        end
        step();
        MemValid = 1'b0;
        toNeg();
        assertCount++;
        if (AluReady !== 1'b1) begin
            errCount++;
            $display("FAIL arb_alu_next: got %b, required 1", AluReady);
        end
        step();
        AluValid = 1'b0;
        step();
        toNeg();
        assertCount++;
        if (Count !== 3'd0) begin
            errCount++;
            $display("FAIL arb_drained: got Count=%0d, required 0", Count);
        end
        step();
        $display("test_arbitration done");
    endtask

    task automatic test_fill_stall();
        WrStall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            AluValid = 1'b1; AluRd = AW'(i); AluData = 64'h100 + 64'(i);
            expectWrite(AW'(i), 64'h100 + 64'(i));
            toNeg();
            assertCount++;
            if (AluReady !== 1'b1) begin
                errCount++;
                $display("FAIL fill_ready_%0d: got %b, required 1", i, AluReady);
            end
            step();
        end
        AluRd = 5'd5; AluData = 64'h105;
        expectWrite(5'd5, 64'h105);
        toNeg();
        assertCount++;
        if (AluReady !== 1'b0 || MemReady !== 1'b0 || Count !== 3'd4 || RegWr !== 1'b0) begin
            errCount++;
            $display("FAIL fill_full: got Alu=%b Mem=%b Count=%0d RegWr=%b, required 0 0 4 0", AluReady, MemReady, Count, RegWr);
        end
        step();
        WrStall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            toNeg();
            assertCount++;
            if (RegWr !== 1'b1 || RW !== AW'(j + 1)) begin
                errCount++;
                $display("FAIL fill_retire_%0d: got RegWr=%b RW=%0d, required 1 %0d", j, RegWr, RW, j + 1);
            end
            step();
            if (j == 1) AluValid = 1'b0;
        end
        toNeg();
        assertCount++;
        if (Count !== 3'd0) begin
            errCount++;
            $display("FAIL fill_drained: got Count=%0d, required 0", Count);
        end
        step();
        $display("test_fill_stall done");
    endtask

    task automatic test_forward();
        WrStall = 1'b1;
        AluValid = 1'b1; AluRd = 5'd7; AluData = 64'h11;
        expectWrite(5'd7, 64'h11);
        step();
        AluData = 64'h22;
        expectWrite(5'd7, 64'h22);
        step();
        AluValid = 1'b0;
        LookA = 5'd7; LookB = 5'd8;
        toNeg();
        assertCount++;
        if (FwdHitA !== 1'b1 || FwdDataA !== 64'h22) begin
            errCount++;
            $display("FAIL fwd_youngest: got hit=%b data=%0h, required 1 22", FwdHitA, FwdDataA);
        end
        assertCount++;
        if (FwdHitB !== 1'b0 || FwdDataB !== 64'd0) begin
            errCount++;
            $display("FAIL fwd_miss: got hit=%b data=%0h, required 0 0", FwdHitB, FwdDataB);
        end
        step();
        WrStall = 1'b0;
        LookB = 5'd7;
        toNeg();
        assertCount++;
        if (FwdHitB !== 1'b1 || FwdDataB !== 64'h22) begin
            errCount++;
            $display("FAIL fwd_b_hit: got hit=%b data=%0h, required 1 22", FwdHitB, FwdDataB);
        end
        step();
        toNeg();
        assertCount++;
        if (FwdHitA !== 1'b1 || FwdDataA !== 64'h22 || Count !== 3'd1) begin
            errCount++;
            $display("FAIL fwd_head_only: got hit=%b data=%0h Count=%0d, required 1 22 1", FwdHitA, FwdDataA, Count);
        end
        step();
        toNeg();
        assertCount++;
        if (FwdHitA !== 1'b0 || FwdDataA !== 64'd0) begin
            errCount++;
            $display("FAIL fwd_after_drain: got hit=%b data=%0h, required 0 0", FwdHitA, FwdDataA);
        end
        step();
        $display("test_forward done");
    endtask

    task automatic test_xzr();
        MemValid = 1'b1; MemRd = 5'd31; MemData = 64'hDEAD;
        toNeg();
        assertCount++;
        if (MemReady !== 1'b1) begin
            errCount++;
            $display("FAIL xzr_ready: got %b, required 1", MemReady);
        end
        step();
        MemValid = 1'b0;
        LookA = 5'd31;
        toNeg();
        assertCount++;
        if (Count !== 3'd0 || RegWr !== 1'b0 || FwdHitA !== 1'b0) begin
            errCount++;
            $display("FAIL xzr_discard: got Count=%0d RegWr=%b hitA=%b, required 0 0 0", Count, RegWr, FwdHitA);
        end
        step();
        $display("test_xzr done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            AluValid = 1'b1; AluRd = AW'(20 + i); AluData = 64'hB00 + 64'(i);
            expectWrite(AW'(20 + i), 64'hB00 + 64'(i));
            toNeg();
            assertCount++;
            if (AluReady !== 1'b1 || (i > 0 && Count !== 3'd1)) begin
                errCount++;
                $display("FAIL b2b_%0d: got Alu=%b Count=%0d, required 1 %0d", i, AluReady, Count, (i > 0) ? 1 : 0);
            end
            step();
        end
        AluValid = 1'b0;
        step();
        toNeg();
        assertCount++;
        if (Count !== 3'd0) begin
            errCount++;
            $display("FAIL b2b_drained: got Count=%0d, required 0", Count);
        end
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        WrStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MemValid = 1'b1; MemRd = AW'(10 + i); MemData = 64'hC00 + 64'(i);
            expectWrite(AW'(10 + i), 64'hC00 + 64'(i));
            step();
        end
        MemValid = 1'b0;
        toNeg();
        assertCount++;
        if (Count !== 3'd3) begin
            errCount++;
            $display("FAIL rstmid_queued: got Count=%0d, required 3", Count);
        end
        step();
        ResetL = 1'b0;
        step();
        ResetL = 1'b1;
        WrStall = 1'b0;
        expQ.delete();
        toNeg();
        assertCount++;
        if (Count !== 3'd0 || RegWr !== 1'b0) begin
            errCount++;
            $display("FAIL rstmid_cleared: got Count=%0d RegWr=%b, required 0 0", Count, RegWr);
        end
        for (int i = 0; i < 5; i++) step();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_arbitration();
        test_fill_stall();
        test_forward();
        test_xzr();
        test_back_to_back();
        test_reset_mid();
        toNeg();
        assertCount++;
        if (expQ.size() != 0) begin
            errCount++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
        $finish;
    end

endmodule
